// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and the bridge state type.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } bridge_state_t;

endpackage

// File: rtl/apb_slave_mux.sv
// Slave decode for the APB segment: range check of an incoming index,
// one-hot select for the active index, and return-path selection.
module apb_slave_mux #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]          acc_idx,
  input  logic [IDX_W-1:0]          cur_idx,
  input  logic                      sel_en,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic                      acc_idx_ok,
  output logic [NUM_SLV-1:0]        psel,
  output logic [DATA_W-1:0]         sel_rdata,
  output logic                      sel_ready,
  output logic                      sel_err
);

  // An index field wider than needed (non power-of-two count) can name a missing slave.
  assign acc_idx_ok = (32'(acc_idx) < NUM_SLV);

  // Pick the addressed slave's read data, ready and error.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        sel_rdata = prdata[i*DATA_W +: DATA_W];
        sel_ready = pready[i];
        sel_err   = pslverr[i];
      end
    end
  end

  // One-hot select, kept separate so it never feeds back into the return path.
  always_comb begin
    psel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel[i] = sel_en && (cur_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mp.sv
// Parametrised AHB-to-APB bridge: single AHB transfers onto a multi-slave
// APB segment with wait states and two-cycle ERROR responses.
module ahb_apb_bridge_mp
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hselapb,
  input  logic                      hwrite,
  input  logic [1:0]                htrans,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [DATA_W-1:0]         hwdata,
  output logic [DATA_W-1:0]         hrdata,
  output logic                      hready,
  output logic                      hresp,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      pwrite,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  bridge_state_t    state_q, state_d, dispatch;
  logic [IDX_W-1:0] idx_q;
  logic             valid, accept, acc_idx_ok, sel_en;
  logic             sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_mux (
    .acc_idx    (haddr[SEL_LSB +: IDX_W]),
    .cur_idx    (idx_q),
    .sel_en     (sel_en),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .acc_idx_ok (acc_idx_ok),
    .psel       (psel),
    .sel_rdata  (sel_rdata),
    .sel_ready  (sel_ready),
    .sel_err    (sel_err)
  );

  assign valid    = hselapb && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign accept   = valid && hready;
  assign dispatch = !acc_idx_ok ? ERR1 : (hwrite ? WDATA : SETUP);
  assign sel_en   = (state_q == SETUP) || (state_q == ACCESS);
  assign penable  = (state_q == ACCESS);
  assign hrdata   = (state_q == ACCESS && !pwrite && sel_ready && !sel_err) ? sel_rdata : '0;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge hclk) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // AHB handshake outputs, decoded from state and the selected slave's response.
  always_comb begin
    hready = 1'b0;
    hresp  = HRESP_OKAY;
    case (state_q)
      IDLE:    hready = 1'b1;
      ACCESS:  hready = sel_ready && !sel_err;
      ERR1:    hresp  = HRESP_ERROR;
      ERR2: begin
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Next state; an OKAY completion or ERR2 may start the next transfer directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dispatch;
      WDATA:   state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          if (sel_err)     state_d = ERR1;
          else if (accept) state_d = dispatch;
          else             state_d = IDLE;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = accept ? dispatch : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address-phase capture on acceptance and write-data capture one cycle later.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      idx_q  <= '0;
    end else begin
      if (accept) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        idx_q  <= haddr[SEL_LSB +: IDX_W];
      end
      if (state_q == WDATA) pwdata <= hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Scoreboard bench for ahb_apb_bridge_mp: stimulus queues expected AHB and
// APB completions, independent monitors pop and compare them.
module tb_ahb_apb_bridge_mp;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          lat;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } apb_exp_t;

  logic        hclk = 1'b0;
  logic        hresetn, hselapb, hsel3, hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic [31:0] hrdata, paddr, pwdata;
  logic        hready, hresp, pwrite, penable;
  logic [3:0]  psel, pready, pslverr;
  logic [127:0] prdata;

  logic [31:0] hrdata3, paddr3, pwdata3;
  logic        hready3, hresp3, pwrite3, penable3;
  logic [2:0]  psel3;
  logic        psel3_seen = 1'b0;

  int          wait_cfg[4];
  logic [3:0]  err_cfg;
  int          acc_cnt = 0;

  int          checks = 0;
  int          errors = 0;
  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];

  always #5 hclk = ~hclk;

  assign prdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0A0A_0A0A};

  ahb_apb_bridge_mp #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(12)) dut (
    .hclk(hclk), .hresetn(hresetn), .hselapb(hselapb), .hwrite(hwrite),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .psel(psel), .penable(penable), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  ahb_apb_bridge_mp #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(12)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hselapb(hsel3), .hwrite(hwrite),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata3),
    .hready(hready3), .hresp(hresp3), .paddr(paddr3), .pwdata(pwdata3),
    .pwrite(pwrite3), .psel(psel3), .penable(penable3), .prdata(96'h0),
    .pready(3'b111), .pslverr(3'b000)
  );

  // APB slave model: each slave holds pready low for wait_cfg cycles of ACCESS
  always @(posedge hclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    for (int i = 0; i < 4; i++) begin
      pready[i]  = (acc_cnt >= wait_cfg[i]);
      pslverr[i] = err_cfg[i] & pready[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // AHB monitor: times each accepted transfer until hready closes its data phase
  always @(negedge hclk) begin : ahb_mon
    bit       busy;
    int       cyc;
    ahb_exp_t e;
    if (!hresetn) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        cyc++;
        if (hready) begin
          busy = 1'b0;
          if (ahb_q.size() == 0) begin
            checkOutput("ahb_unexpected_response", 32'(ahb_q.size()), 32'd1);
          end else begin
            e = ahb_q.pop_front();
            checkOutput("ahb_hresp", {31'd0, hresp}, {31'd0, e.resp});
            checkOutput("ahb_hrdata", hrdata, e.rdata);
            checkOutput("ahb_latency", cyc, e.lat);
          end
        end else if (cyc > 30) begin
          busy = 1'b0;
          checkOutput("ahb_response_timeout", {31'd0, hready}, 32'd1);
        end
      end
      if (hselapb && htrans[1] && hready) begin
        busy = 1'b1;
        cyc  = 0;
      end
    end
  end

  // APB monitor: every completing ACCESS cycle must match the next queued transfer
  always @(negedge hclk) begin : apb_mon
    apb_exp_t e;
    if (hresetn && penable && |(psel & pready)) begin
      if (apb_q.size() == 0) begin
        checkOutput("apb_unexpected_transfer", 32'(apb_q.size()), 32'd1);
      end else begin
        e = apb_q.pop_front();
        checkOutput("apb_paddr", paddr, e.addr);
        checkOutput("apb_pwrite", {31'd0, pwrite}, {31'd0, e.wr});
        checkOutput("apb_psel", {28'd0, psel}, {28'd0, e.sel});
        if (e.wr) checkOutput("apb_pwdata", pwdata, e.wdata);
      end
    end
  end

  // Decode-error bridge must never drive any select line
  always @(negedge hclk) if (hresetn && psel3 != 3'b000) psel3_seen = 1'b1;

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_resp, input logic [31:0] exp_rdata, input int exp_lat,
                               input logic [3:0] exp_sel, input bit push_exp);
    int guard = 0;
    if (push_exp) begin
      ahb_q.push_back('{resp: exp_resp, rdata: exp_rdata, lat: exp_lat});
      apb_q.push_back('{addr: addr, wr: wr, wdata: wdata, sel: exp_sel});
    end
    hselapb = 1'b1;
    htrans  = 2'b10;
    haddr   = addr;
    hwrite  = wr;
    do begin
      @(negedge hclk);
      guard++;
    end while (!hready && guard < 40);
    checkOutput("addr_accept", {31'd0, hready}, 32'd1);
    @(posedge hclk);
    #1;
    hselapb = 1'b0;
    htrans  = 2'b00;
    hwdata  = wdata;
  endtask

  task automatic drainQueues();
    int guard = 0;
    while ((ahb_q.size() != 0 || apb_q.size() != 0) && guard < 40) begin
      @(negedge hclk);
      guard++;
    end
    if (ahb_q.size() != 0 || apb_q.size() != 0) begin
      checkOutput("queue_drain", 32'(ahb_q.size() + apb_q.size()), 32'd0);
      ahb_q.delete();
      apb_q.delete();
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    hresetn = 1'b0;
    hselapb = 1'b0;
    hsel3   = 1'b0;
    hwrite  = 1'b0;
    htrans  = 2'b00;
    haddr   = '0;
    hwdata  = '0;
    err_cfg = '0;
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;

    // Reset state
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    checkOutput("rst_hready", {31'd0, hready}, 32'd1);
    checkOutput("rst_hresp", {31'd0, hresp}, 32'd0);
    checkOutput("rst_psel", {28'd0, psel}, 32'd0);
    checkOutput("rst_penable", {31'd0, penable}, 32'd0);
    checkOutput("rst_pwrite", {31'd0, pwrite}, 32'd0);
    checkOutput("rst_paddr", paddr, 32'd0);
    checkOutput("rst_pwdata", pwdata, 32'd0);
    checkOutput("rst3_hready", {31'd0, hready3}, 32'd1);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Read slave 1, zero waits
    applyStimulus(1'b0, 32'h0000_1010, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 4'b0010, 1'b1);
    @(negedge hclk);
    checkOutput("rd_setup_psel", {28'd0, psel}, 32'h2);
    checkOutput("rd_setup_penable", {31'd0, penable}, 32'd0);
    @(negedge hclk);
    checkOutput("rd_access_psel", {28'd0, psel}, 32'h2);
    checkOutput("rd_access_penable", {31'd0, penable}, 32'd1);
    checkOutput("rd_access_hready", {31'd0, hready}, 32'd1);
    drainQueues();

    // Write slave 3 with three wait states
    wait_cfg[3] = 3;
    applyStimulus(1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 1'b0, 32'h0, 6, 4'b1000, 1'b1);
    @(negedge hclk);
    checkOutput("wr_wdata_psel", {28'd0, psel}, 32'd0);
    checkOutput("wr_wdata_hready", {31'd0, hready}, 32'd0);
    @(negedge hclk);
    checkOutput("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_setup_psel", {28'd0, psel}, 32'h8);
    drainQueues();
    wait_cfg[3] = 0;

    // Read slave 2 with slave error
    err_cfg[2] = 1'b1;
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 4, 4'b0100, 1'b1);
    @(negedge hclk);
    @(negedge hclk);
    checkOutput("serr_access_hready", {31'd0, hready}, 32'd0);
    checkOutput("serr_access_hresp", {31'd0, hresp}, 32'd0);
    @(negedge hclk);
    checkOutput("serr_err1_hready", {31'd0, hready}, 32'd0);
    checkOutput("serr_err1_hresp", {31'd0, hresp}, 32'd1);
    checkOutput("serr_err1_psel", {28'd0, psel}, 32'd0);
    @(negedge hclk);
    checkOutput("serr_err2_hready", {31'd0, hready}, 32'd1);
    checkOutput("serr_err2_hresp", {31'd0, hresp}, 32'd1);
    @(negedge hclk);
    checkOutput("serr_idle_hresp", {31'd0, hresp}, 32'd0);
    checkOutput("serr_idle_hready", {31'd0, hready}, 32'd1);
    err_cfg[2] = 1'b0;
    drainQueues();

    // Decode error on the three-slave bridge
    hsel3  = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h0000_3000;
    hwrite = 1'b0;
    @(negedge hclk);
    checkOutput("dec_accept_hready", {31'd0, hready3}, 32'd1);
    @(posedge hclk);
    #1;
    hsel3  = 1'b0;
    htrans = 2'b00;
    @(negedge hclk);
    checkOutput("dec_err1_hready", {31'd0, hready3}, 32'd0);
    checkOutput("dec_err1_hresp", {31'd0, hresp3}, 32'd1);
    @(negedge hclk);
    checkOutput("dec_err2_hready", {31'd0, hready3}, 32'd1);
    checkOutput("dec_err2_hresp", {31'd0, hresp3}, 32'd1);
    @(negedge hclk);
    checkOutput("dec_idle_hresp", {31'd0, hresp3}, 32'd0);
    @(posedge hclk);
    #1;

    // Back-to-back read then write, write issued during the read's ACCESS
    applyStimulus(1'b0, 32'h0000_1020, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 4'b0010, 1'b1);
    applyStimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0, 3, 4'b0001, 1'b1);
    @(negedge hclk);
    checkOutput("b2b_wdata_psel", {28'd0, psel}, 32'd0);
    checkOutput("b2b_wdata_penable", {31'd0, penable}, 32'd0);
    @(negedge hclk);
    checkOutput("b2b_setup_psel", {28'd0, psel}, 32'h1);
    drainQueues();

    // Reset during an ACCESS wait state, then a normal read
    wait_cfg[0] = 5;
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0, 0, 4'b0001, 1'b0);
    @(negedge hclk);
    @(negedge hclk);
    checkOutput("rstw_wait_penable", {31'd0, penable}, 32'd1);
    checkOutput("rstw_wait_hready", {31'd0, hready}, 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    @(negedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(negedge hclk);
    checkOutput("rstw_psel", {28'd0, psel}, 32'd0);
    checkOutput("rstw_penable", {31'd0, penable}, 32'd0);
    checkOutput("rstw_hready", {31'd0, hready}, 32'd1);
    checkOutput("rstw_hresp", {31'd0, hresp}, 32'd0);
    @(posedge hclk);
    #1;
    wait_cfg[0] = 0;
    applyStimulus(1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0A0A_0A0A, 2, 4'b0001, 1'b1);
    drainQueues();

    checkOutput("dec_psel_never_set", {31'd0, psel3_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
